sample_window8: RTL

- Upstream feeder for the team's 8-input adder/subtractor tree.
- Accepts a serial stream of N-bit samples over a valid/ready handshake and collects them into windows of eight.
- Presents each window as eight parallel, registered words x0..x7 with an output valid/ready handshake, so the combinational tree always sees stable operands.
- Double-buffered: the next window fills while the current one is held for the consumer.

---
 rtl/sample_window8.sv | 117 +++++++++++
 1 files changed

// File: rtl/sample_window8.sv
// Collects a valid/ready sample stream into eight-word windows with a double buffer.
// Define WINDOW_SLIDE_EN for sliding windows; the default build produces tumbling windows.
module sample_window8 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x0,
    output logic [N-1:0] x1,
    output logic [N-1:0] x2,
    output logic [N-1:0] x3,
    output logic [N-1:0] x4,
    output logic [N-1:0] x5,
    output logic [N-1:0] x6,
    output logic [N-1:0] x7,
    output logic [3:0]   fill_cnt
);

    logic [N-1:0] fbuf [8];
    logic [N-1:0] xr   [8];
    logic [N-1:0] win  [8];
    logic         out_free;
    logic         accept;
    logic         pend;
    logic         load_in;
    logic         load_pend;

    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef WINDOW_SLIDE_EN
    logic primed;
    logic pend_q;

    // A window completed while the output was busy still waits in fbuf, exactly as in block mode.
    assign pend      = pend_q;
    assign primed    = (fill_cnt == 4'd8) && !pend_q;
    assign in_ready  = !flush && (primed ? out_free : !pend);
    assign load_in   = accept && out_free && (primed || fill_cnt == 4'd7);
    assign load_pend = pend && out_free && !flush;
`else
    assign pend      = (fill_cnt == 4'd8);
    assign in_ready  = !flush && !pend;
    assign load_in   = accept && out_free && (fill_cnt == 4'd7);
    assign load_pend = pend && out_free && !flush;
`endif

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        for (int i = 0; i < 8; i++) win[i] = fbuf[i];
        if (load_in) begin
`ifdef WINDOW_SLIDE_EN
            for (int i = 0; i < 7; i++) win[i] = fbuf[i+1];
`endif
            win[7] = in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the fill buffer is reset along with the control state so no stale word is ever visible.
            for (int i = 0; i < 8; i++) fbuf[i] <= '0;
            fill_cnt <= '0;
`ifdef WINDOW_SLIDE_EN
            pend_q <= 1'b0;
`endif
        end else begin
`ifdef WINDOW_SLIDE_EN
            if (accept) begin
                for (int i = 0; i < 7; i++) fbuf[i] <= fbuf[i+1];
                fbuf[7] <= in_data;
            end
            if (flush) begin
                fill_cnt <= '0;
                pend_q   <= 1'b0;
            end else begin
                if (accept && fill_cnt != 4'd8) fill_cnt <= fill_cnt + 4'd1;
                if (accept && fill_cnt == 4'd7 && !out_free) pend_q <= 1'b1;
                else if (load_pend)                          pend_q <= 1'b0;
            end
`else
            if (accept) fbuf[fill_cnt[2:0]] <= in_data;
            if (flush || load_in || load_pend) fill_cnt <= '0;
            else if (accept)                   fill_cnt <= fill_cnt + 4'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) xr[i] <= '0;
            out_valid <= 1'b0;
        end else if (load_in || load_pend) begin
            for (int i = 0; i < 8; i++) xr[i] <= win[i];
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign x0 = xr[0];
    assign x1 = xr[1];
    assign x2 = xr[2];
    assign x3 = xr[3];
    assign x4 = xr[4];
    assign x5 = xr[5];
    assign x6 = xr[6];
    assign x7 = xr[7];

endmodule
